// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: shared VeriRISC opcode/state enums, strobe bundle and ALU-op helper
package cpu_controller_pkg;
  typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
  typedef enum logic [2:0] {INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE} state_t;
  typedef struct packed {
    logic mem_rd;
    logic load_ir;
    logic halt;
    logic inc_pc;
    logic load_ac;
    logic load_pc;
    logic mem_wr;
    logic data_e;
  } ctrl_t;
  function automatic logic is_aluop(opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction
endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: opcode/zero in, datapath strobes out; master = controller, slave = datapath
interface cpu_controller_if;
  import cpu_controller_pkg::*;
  opcode_t opcode;
  logic zero;
  logic mem_rd;
  logic load_ir;
  logic halt;
  logic inc_pc;
  logic load_ac;
  logic load_pc;
  logic mem_wr;
  logic data_e;
  modport master (
    input  opcode, zero,
    output mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e
  );
  modport slave (
    output opcode, zero,
    input  mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e
  );
endinterface

// File: rtl/cpu_controller_decode.sv
// cpu_ctrl_decode: combinational state+opcode+zero -> datapath strobes (ctrl)
module cpu_ctrl_decode
  import cpu_controller_pkg::*;
(
  input  state_t  state,
  input  opcode_t opcode,
  input  logic    zero,
  output ctrl_t   ctrl
);
  logic alu;
  assign alu = is_aluop(opcode);
  always_comb begin
    ctrl = '0;
    case (state)
      INST_FETCH: ctrl.mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        ctrl.mem_rd  = 1'b1;
        ctrl.load_ir = 1'b1;
      end
      OP_ADDR: begin
        ctrl.inc_pc = 1'b1;
        ctrl.halt   = opcode == HLT;
      end
      OP_FETCH: ctrl.mem_rd = alu;
      ALU_OP: begin
        ctrl.mem_rd  = alu;
        ctrl.load_ac = alu;
        ctrl.inc_pc  = opcode == SKZ && zero;
        ctrl.load_pc = opcode == JMP;
        ctrl.data_e  = opcode == STO;
      end
      STORE: begin
        ctrl.mem_rd  = alu;
        ctrl.load_ac = alu;
        ctrl.inc_pc  = opcode == JMP;
        ctrl.load_pc = opcode == JMP;
        ctrl.mem_wr  = opcode == STO;
        ctrl.data_e  = opcode == STO;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase VeriRISC sequencer; ports clk, rst (async high), bus (cpu_controller_if.master), step when CPU_CTRL_SINGLE_STEP_EN; HALT_STICKY freezes on HLT
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input logic clk,
  input logic rst,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input logic step,
`endif
  cpu_controller_if.master bus
);
  state_t state, state_n;
  ctrl_t ctrl;
  logic frozen, go;
  assign frozen = HALT_STICKY && state == OP_ADDR && bus.opcode == HLT;
`ifdef CPU_CTRL_SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) step_q <= 1'b0;
    else step_q <= step;
  assign go = step & ~step_q;
`else
  assign go = 1'b1;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= INST_ADDR;
    else state <= state_n;
  always_comb begin
    state_n = (frozen || (state == INST_ADDR && !go)) ? state : state_t'(state + 3'd1);
  end
  cpu_ctrl_decode u_decode (
    .state  (state),
    .opcode (bus.opcode),
    .zero   (bus.zero),
    .ctrl   (ctrl)
  );
  assign bus.mem_rd  = ctrl.mem_rd;
  assign bus.load_ir = ctrl.load_ir;
  assign bus.halt    = ctrl.halt;
  assign bus.inc_pc  = ctrl.inc_pc & ~frozen;
  assign bus.load_ac = ctrl.load_ac;
  assign bus.load_pc = ctrl.load_pc;
  assign bus.mem_wr  = ctrl.mem_wr;
  assign bus.data_e  = ctrl.data_e;
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst) !(bus.mem_rd && bus.mem_wr));
  a_load_pc_jmp: assert property (@(posedge clk) disable iff (rst) bus.load_pc |-> bus.opcode == JMP);
  a_opcode_known: assert property (@(posedge clk) disable iff (rst) state >= OP_ADDR |-> !$isunknown(bus.opcode));
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: randomized self-checking bench for cpu_controller against a phase-level model
module tb_cpu_controller;
  import cpu_controller_pkg::*;
`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step_i = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int ph_a = 0;
  int ph_b = 0;
  bit prev_step = 1'b0;
  cpu_controller_if bus_a ();
  cpu_controller_if bus_b ();
  always #5 clk = ~clk;
  cpu_controller #(.HALT_STICKY(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step (step_i),
`endif
    .bus (bus_a.master)
  );
  cpu_controller #(.HALT_STICKY(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step (step_i),
`endif
    .bus (bus_b.master)
  );
  function automatic logic [10:0] exp_vec(int ph, opcode_t op, logic z, bit sticky);
    bit alu;
    logic [7:0] o;
    logic [2:0] p;
    alu = op inside {ADD, AND, XOR, LDA};
    p = ph[2:0];
    o[7] = ph inside {1, 2, 3} || (ph >= 5 && alu);
    o[6] = ph == 2 || ph == 3;
    o[5] = ph == 4 && op == HLT;
    o[4] = (ph == 4 && !(sticky && op == HLT)) || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP);
    o[3] = ph >= 6 && alu;
    o[2] = ph >= 6 && op == JMP;
    o[1] = ph == 7 && op == STO;
    o[0] = ph >= 6 && op == STO;
    return {p, o};
  endfunction
  function automatic int nxt(int ph, opcode_t op, bit go, bit sticky);
    if (sticky && ph == 4 && op == HLT) return 4;
    if (ph == 0 && !go) return 0;
    return (ph + 1) % 8;
  endfunction
  function automatic logic [10:0] obs_a();
    return {dut_a.state, bus_a.mem_rd, bus_a.load_ir, bus_a.halt, bus_a.inc_pc, bus_a.load_ac, bus_a.load_pc, bus_a.mem_wr, bus_a.data_e};
  endfunction
  function automatic logic [10:0] obs_b();
    return {dut_b.state, bus_b.mem_rd, bus_b.load_ir, bus_b.halt, bus_b.inc_pc, bus_b.load_ac, bus_b.load_pc, bus_b.mem_wr, bus_b.data_e};
  endfunction
  task automatic set_in(input opcode_t op, input logic z);
    bus_a.opcode = op;
    bus_b.opcode = op;
    bus_a.zero = z;
    bus_b.zero = z;
  endtask
  task automatic tick();
    bit go;
    @(posedge clk);
    go = !SS || (step_i && !prev_step);
    prev_step = step_i;
    ph_a = nxt(ph_a, bus_a.opcode, go, 1'b1);
    ph_b = nxt(ph_b, bus_b.opcode, go, 1'b0);
    #2;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    ph_a = 0;
    ph_b = 0;
    prev_step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    set_in(ADD, 1'b0);
    step_i = 1'b1;
    do_reset();
    vectors++;
    if (obs_a() !== exp_vec(0, ADD, 1'b0, 1'b1)) begin
      miscompares++;
      $display("FAIL reset_idle got %h exp %h", obs_a(), exp_vec(0, ADD, 1'b0, 1'b1));
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (obs_a() !== exp_vec(ph_a, ADD, 1'b0, 1'b1)) begin
        miscompares++;
        $display("FAIL reset_run ph%0d got %h exp %h", ph_a, obs_a(), exp_vec(ph_a, ADD, 1'b0, 1'b1));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({dut_a.state, bus_a.load_ac, bus_a.mem_rd} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_async got %b exp 00000", {dut_a.state, bus_a.load_ac, bus_a.mem_rd});
    end
    ph_a = 0;
    ph_b = 0;
    prev_step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    vectors++;
    if ({dut_a.state, bus_a.mem_rd} !== 4'b0011) begin
      miscompares++;
      $display("FAIL reset_release got %b exp 0011", {dut_a.state, bus_a.mem_rd});
    end
  endtask
  task automatic test_add();
    int wr_cnt;
    wr_cnt = 0;
    set_in(ADD, 1'b0);
    step_i = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      wr_cnt += int'(bus_a.mem_wr);
      vectors++;
      if (obs_a() !== exp_vec(ph_a, ADD, 1'b0, 1'b1)) begin
        miscompares++;
        $display("FAIL add ph%0d got %h exp %h", ph_a, obs_a(), exp_vec(ph_a, ADD, 1'b0, 1'b1));
      end
    end
    vectors++;
    if (wr_cnt !== 0 || ph_a !== 0) begin
      miscompares++;
      $display("FAIL add_wrap mem_wr count %0d phase %0d exp 0 0", wr_cnt, ph_a);
    end
  endtask
  task automatic test_skz();
    int inc_cnt;
    for (int z = 1; z >= 0; z--) begin
      inc_cnt = 0;
      set_in(SKZ, 1'(z));
      step_i = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
        tick();
        inc_cnt += int'(bus_a.inc_pc);
        vectors++;
        if (obs_a() !== exp_vec(ph_a, SKZ, 1'(z), 1'b1)) begin
          miscompares++;
          $display("FAIL skz z%0d ph%0d got %h exp %h", z, ph_a, obs_a(), exp_vec(ph_a, SKZ, 1'(z), 1'b1));
        end
      end
      vectors++;
      if (inc_cnt !== z + 1) begin
        miscompares++;
        $display("FAIL skz_incs z%0d got %0d exp %0d", z, inc_cnt, z + 1);
      end
    end
  endtask
  task automatic test_sto_jmp();
    opcode_t ops[2];
    ops[0] = STO;
    ops[1] = JMP;
    foreach (ops[k]) begin
      set_in(ops[k], 1'b1);
      step_i = 1'b1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
        tick();
        vectors++;
        if (obs_a() !== exp_vec(ph_a, ops[k], 1'b1, 1'b1)) begin
          miscompares++;
          $display("FAIL %s ph%0d got %h exp %h", ops[k].name(), ph_a, obs_a(), exp_vec(ph_a, ops[k], 1'b1, 1'b1));
        end
      end
    end
  endtask
  task automatic test_hlt();
    int halt_b;
    halt_b = 0;
    set_in(HLT, 1'b0);
    step_i = 1'b1;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      tick();
      halt_b += int'(bus_b.halt);
      vectors++;
      if (obs_a() !== exp_vec(ph_a, HLT, 1'b0, 1'b1)) begin
        miscompares++;
        $display("FAIL hlt_sticky ph%0d got %h exp %h", ph_a, obs_a(), exp_vec(ph_a, HLT, 1'b0, 1'b1));
      end
      vectors++;
      if (obs_b() !== exp_vec(ph_b, HLT, 1'b0, 1'b0)) begin
        miscompares++;
        $display("FAIL hlt_pulse ph%0d got %h exp %h", ph_b, obs_b(), exp_vec(ph_b, HLT, 1'b0, 1'b0));
      end
    end
    vectors++;
    if (halt_b !== (SS ? 1 : 3)) begin
      miscompares++;
      $display("FAIL hlt_pulse_count got %0d exp %0d", halt_b, SS ? 1 : 3);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (obs_a() !== exp_vec(0, HLT, 1'b0, 1'b1)) begin
      miscompares++;
      $display("FAIL hlt_reset got %h exp %h", obs_a(), exp_vec(0, HLT, 1'b0, 1'b1));
    end
  endtask
  task automatic test_random();
    opcode_t op;
    logic z;
    op = ADD;
    z = 1'b0;
    step_i = 1'b0;
    set_in(op, z);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick();
      vectors++;
      if (obs_a() !== exp_vec(ph_a, op, z, 1'b1)) begin
        miscompares++;
        $display("FAIL rand_a %s ph%0d got %h exp %h", op.name(), ph_a, obs_a(), exp_vec(ph_a, op, z, 1'b1));
      end
      vectors++;
      if (obs_b() !== exp_vec(ph_b, op, z, 1'b0)) begin
        miscompares++;
        $display("FAIL rand_b %s ph%0d got %h exp %h", op.name(), ph_b, obs_b(), exp_vec(ph_b, op, z, 1'b0));
      end
      if (ph_a == 0) op = opcode_t'($urandom_range(1, 7));
      z = 1'($urandom);
      step_i = 1'($urandom);
      set_in(op, z);
      #1;
      vectors++;
      if (obs_a() !== exp_vec(ph_a, op, z, 1'b1)) begin
        miscompares++;
        $display("FAIL rand_comb %s ph%0d got %h exp %h", op.name(), ph_a, obs_a(), exp_vec(ph_a, op, z, 1'b1));
      end
    end
  endtask
`ifdef CPU_CTRL_SINGLE_STEP_EN
  task automatic test_single_step();
    int changes;
    state_t last;
    set_in(LDA, 1'b0);
    step_i = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (obs_a() !== exp_vec(ph_a, LDA, 1'b0, 1'b1)) begin
        miscompares++;
        $display("FAIL step_wait got %h exp %h", obs_a(), exp_vec(ph_a, LDA, 1'b0, 1'b1));
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      changes = 0;
      last = dut_a.state;
      step_i = 1'b1;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (pass == 0) step_i = 1'b0;
        if (dut_a.state != last) changes++;
        last = dut_a.state;
        vectors++;
        if (obs_a() !== exp_vec(ph_a, LDA, 1'b0, 1'b1)) begin
          miscompares++;
          $display("FAIL step_run p%0d ph%0d got %h exp %h", pass, ph_a, obs_a(), exp_vec(ph_a, LDA, 1'b0, 1'b1));
        end
      end
      vectors++;
      if (changes !== 8) begin
        miscompares++;
        $display("FAIL step_count p%0d got %0d exp 8", pass, changes);
      end
      step_i = 1'b0;
      tick();
    end
  endtask
`endif
  initial begin
    set_in(ADD, 1'b0);
    test_reset();
    test_add();
    test_skz();
    test_sto_jmp();
    test_hlt();
    test_random();
`ifdef CPU_CTRL_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction-sequencing FSM for the 8-bit VeriRISC datapath.
- Sits upstream of the ALU, accumulator, program counter and memory.
- Steps through an 8-phase instruction cycle and decodes the current opcode, plus the ALU zero flag, into the datapath control strobes.
- The ALU result is latched into the accumulator only when this block asserts load_ac.

Parameters:
- HALT_STICKY, default 1: 1 = FSM freezes in OP_ADDR with halt held high until reset; 0 = halt is a one-phase pulse and sequencing continues.

Ports:
- clk  input  1  system clock; state advances on posedge (ALU samples on negedge).
- rst  input  1  asynchronous, active-high reset.
- opcode  input  opcode_t (3)  current instruction register opcode.
- zero  input  1  accumulator-zero flag from ALU.
- mem_rd  output  1  memory read enable.
- load_ir  output  1  instruction register load.
- halt  output  1  processor halted.
- inc_pc  output  1  program counter increment.
- load_ac  output  1  accumulator load.
- load_pc  output  1  program counter load (jump).
- mem_wr  output  1  memory write strobe.
- data_e  output  1  data bus drive enable (store).

Behaviour:
- Clock and reset:
  - Single clock clk; asynchronous active-high reset rst.
  - rst high: state = INST_ADDR immediately, all outputs 0, regardless of clock. This holds mid-instruction too.
  - After rst deasserts, the first posedge moves the FSM to INST_FETCH.
- State encoding: state_t, 3 bits, in this order:
  - INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Transitions: state increments by one each posedge; STORE wraps to INST_ADDR. One instruction = 8 clocks.
- Outputs are combinational decode of the registered state and opcode; no extra latency.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Decode by state:
  - INST_ADDR: all outputs 0.
  - INST_FETCH: mem_rd=1.
  - INST_LOAD: mem_rd=1, load_ir=1.
  - IDLE: mem_rd=1, load_ir=1.
  - OP_ADDR: inc_pc=1, halt=(opcode==HLT).
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP), data_e=(opcode==STO).
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO), data_e=(opcode==STO).
- HLT handling:
  - HALT_STICKY=1: on reaching OP_ADDR with opcode==HLT, the FSM stays in OP_ADDR. halt=1 and inc_pc=0 while frozen; only rst exits.
  - HALT_STICKY=0: halt=1 for the single OP_ADDR cycle and sequencing continues.
- zero is sampled combinationally only in ALU_OP; its value in other states is ignored.
- opcode is expected stable from INST_LOAD onward. X on opcode in or after OP_ADDR is flagged by an assertion.
- mem_rd and mem_wr are never both 1 (assertion). load_pc implies opcode==JMP (assertion).

Optional Feature:
- Macro: CPU_CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - FSM waits in INST_ADDR, all outputs 0, until a rising edge of step is detected (step registered, edge = step & ~step_q).
  - The following posedge enters INST_FETCH, and one full instruction runs back to INST_ADDR.
  - step held high runs exactly one instruction.
  - rst clears step_q.
- Undefined: no step port; free-running behaviour as above.

Decomposition:
- Package typedefs:
  - opcode_t enum (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7), already shared with the ALU.
  - New state_t enum.
  - Function is_aluop(opcode_t).
- One natural sub-module, cpu_ctrl_decode: purely combinational state+opcode+zero -> strobes. The FSM register and halt/step logic stay in cpu_controller.

Test Plan:
- Reset: assert rst between clk edges mid-ALU_OP with opcode=ADD -> load_ac, mem_rd drop to 0 immediately. First posedge after release reaches INST_FETCH with mem_rd=1.
- ADD sequence: opcode=ADD held, 8 clocks -> mem_rd=1 in states 1,2,3,5,6,7. load_ac=1 only in ALU_OP and STORE. inc_pc=1 only in OP_ADDR. mem_wr never.
- SKZ: opcode=SKZ, zero=1 -> inc_pc=1 in OP_ADDR and ALU_OP (two increments). Repeat with zero=0 -> inc_pc only in OP_ADDR.
- STO/JMP:
  - STO: data_e=1 in ALU_OP and STORE; mem_wr=1 only in STORE; mem_rd=0 throughout phases 5-7.
  - JMP: load_pc=1 in ALU_OP and STORE; inc_pc=1 in OP_ADDR and STORE.
- HLT:
  - HALT_STICKY=1, opcode=HLT -> halt=1 from OP_ADDR onward, state frozen for 20 clocks, all other outputs 0; rst returns to INST_ADDR.
  - HALT_STICKY=0 -> halt high exactly 1 clock and the cycle wraps.
- Single step (macro defined): step=0 for 10 clocks -> state stays INST_ADDR. One-clock step pulse -> exactly 8 further state changes, then waits. step held high 30 clocks -> still one instruction.
